// File: rtl/bof_range_store.sv
// Range store for the heap-overflow detector: records overflow ranges in a
// circular table, answers combinational address lookups, drains new entries.
//
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   clear_i            synchronous clear of all state (beats write/drain)
//   wr_en_i            record range wr_first_i..wr_last_i (order-agnostic)
//   lookup_addr_i      address tested against every valid slot
//   lookup_hit_o/idx_o hit flag and lowest matching slot (0 on miss)
//   drain_*            valid/ready stream of newly recorded ranges
//   pending_o, used_o  undrained entries, valid slots
//   lost_o             sticky: an undrained range was overwritten
module bof_range_store #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_first_i,
  input  logic [ADDR_W-1:0]          wr_last_i,
  input  logic [ADDR_W-1:0]          lookup_addr_i,
  output logic                       lookup_hit_o,
  output logic [$clog2(DEPTH)-1:0]   lookup_idx_o,
  output logic                       drain_valid_o,
  input  logic                       drain_ready_i,
  output logic [ADDR_W-1:0]          drain_first_o,
  output logic [ADDR_W-1:0]          drain_last_o,
  output logic [$clog2(DEPTH):0]     pending_o,
  output logic [$clog2(DEPTH):0]     used_o,
  output logic                       lost_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [ADDR_W-1:0] slot_first_q [DEPTH];
  logic [ADDR_W-1:0] slot_last_q  [DEPTH];
  logic [DEPTH-1:0]  slot_vld_q;
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [IDX_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  pend_q;
  logic              lost_q;

  logic              swap;
  logic [ADDR_W-1:0] n_first;
  logic [ADDR_W-1:0] n_last;
  logic              dup;
  logic              acc;
  logic              xfer;
  logic              pend_full;

  assign swap    = wr_first_i > wr_last_i;
  assign n_first = swap ? wr_last_i : wr_first_i;
  assign n_last  = swap ? wr_first_i : wr_last_i;

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld_q[i] &&
          slot_first_q[i] == n_first &&
          slot_last_q[i] == n_last)
        dup = 1'b1;
    end
  end

  assign acc       = wr_en_i & ~dup;
  assign xfer      = drain_valid_o & drain_ready_i;
  assign pend_full = pend_q == CNT_W'(DEPTH);

  // Slot payload carries no reset; the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (acc && !clear_i) begin
      slot_first_q[wr_ptr_q] <= n_first;
      slot_last_q[wr_ptr_q]  <= n_last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_q     <= '0;
      lost_q     <= 1'b0;
    end else if (clear_i) begin
      slot_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_q     <= '0;
      lost_q     <= 1'b0;
    end else begin
      if (acc) begin
        slot_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q <= wr_ptr_q + IDX_W'(1);
      end
      unique case ({acc, xfer})
        2'b11: rd_ptr_q <= rd_ptr_q + IDX_W'(1);
        2'b10: begin
          // Full drain queue: the write lands on the oldest
          // undrained slot, so the reader skips past it.
          if (pend_full) begin
            rd_ptr_q <= rd_ptr_q + IDX_W'(1);
            lost_q   <= 1'b1;
          end else begin
            pend_q <= pend_q + CNT_W'(1);
          end
        end
        2'b01: begin
          rd_ptr_q <= rd_ptr_q + IDX_W'(1);
          pend_q   <= pend_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    lookup_hit_o = 1'b0;
    lookup_idx_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slot_vld_q[i] &&
          lookup_addr_i >= slot_first_q[i] &&
          lookup_addr_i <= slot_last_q[i]) begin
        lookup_hit_o = 1'b1;
        lookup_idx_o = IDX_W'(i);
      end
    end
  end

  always_comb begin
    used_o = '0;
    for (int i = 0; i < DEPTH; i++)
      used_o = used_o + CNT_W'(slot_vld_q[i]);
  end

  assign drain_valid_o = pend_q != '0;
  assign drain_first_o = slot_first_q[rd_ptr_q];
  assign drain_last_o  = slot_last_q[rd_ptr_q];
  assign pending_o     = pend_q;
  assign lost_o        = lost_q;

endmodule

// File: tb/tb_bof_range_store.sv
// Self-checking bench for bof_range_store: vector table for record,
// swap/duplicate and drain; hand sequences for overflow, clear and reset.
module tb_bof_range_store;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [31:0] wr_first_i = '0;
  logic [31:0] wr_last_i = '0;
  logic [31:0] lookup_addr_i = '0;
  logic        lookup_hit_o;
  logic [2:0]  lookup_idx_o;
  logic        drain_valid_o;
  logic        drain_ready_i = 1'b0;
  logic [31:0] drain_first_o;
  logic [31:0] drain_last_o;
  logic [3:0]  pending_o;
  logic [3:0]  used_o;
  logic        lost_o;

  int n_chk = 0;
  int n_pass = 0;

  bof_range_store #(.DEPTH(8), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .wr_en_i(wr_en_i), .wr_first_i(wr_first_i),
    .wr_last_i(wr_last_i), .lookup_addr_i(lookup_addr_i),
    .lookup_hit_o(lookup_hit_o), .lookup_idx_o(lookup_idx_o),
    .drain_valid_o(drain_valid_o),
    .drain_ready_i(drain_ready_i),
    .drain_first_o(drain_first_o),
    .drain_last_o(drain_last_o), .pending_o(pending_o),
    .used_o(used_o), .lost_o(lost_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        clr;
    logic        wr;
    logic [31:0] f;
    logic [31:0] l;
    logic        rdy;
    logic [31:0] la;
    logic        hit;
    logic [2:0]  idx;
    logic        dv;
    logic [3:0]  pend;
    logic [3:0]  used;
    logic        lost;
    logic [31:0] df;
    logic [31:0] dl;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic drive(input logic clr, input logic wr,
                       input logic [31:0] f, input logic [31:0] l,
                       input logic rdy, input logic [31:0] la);
    clear_i = clr;
    wr_en_i = wr;
    wr_first_i = f;
    wr_last_i = l;
    drain_ready_i = rdy;
    lookup_addr_i = la;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    wr_en_i = 1'b0;
    drain_ready_i = 1'b0;
  endtask

  function automatic vec_t mk(
      input logic clr, input logic wr, input logic [31:0] f,
      input logic [31:0] l, input logic rdy, input logic [31:0] la,
      input logic hit, input logic [2:0] idx, input logic dv,
      input logic [3:0] pend, input logic [3:0] used,
      input logic lost, input logic [31:0] df, input logic [31:0] dl);
    vec_t v;
    v.clr = clr; v.wr = wr; v.f = f; v.l = l; v.rdy = rdy;
    v.la = la; v.hit = hit; v.idx = idx; v.dv = dv;
    v.pend = pend; v.used = used; v.lost = lost;
    v.df = df; v.dl = dl;
    return v;
  endfunction

  task automatic clr_cycle();
    drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
    cyc();
  endtask

  task automatic wr_cycle(input logic [31:0] f, input logic [31:0] l,
                          input logic rdy);
    drive(1'b0, 1'b1, f, l, rdy, 0);
    cyc();
  endtask

  function automatic logic [31:0] rf(input int i);
    return 32'h0001_0000 + 32'(i) * 32'h100;
  endfunction

  initial begin
    // Test 1: basic record and lookup.
    vt.push_back(mk(0,1,32'h1000,32'h1024,0,32'h1000,
                    1,0,1,1,1,0,32'h1000,32'h1024));
    vt.push_back(mk(0,0,0,0,0,32'h1024,1,0,1,1,1,0,32'h1000,32'h1024));
    vt.push_back(mk(0,0,0,0,0,32'h1010,1,0,1,1,1,0,32'h1000,32'h1024));
    vt.push_back(mk(0,0,0,0,0,32'h0FFF,0,0,1,1,1,0,32'h1000,32'h1024));
    vt.push_back(mk(0,0,0,0,0,32'h1025,0,0,1,1,1,0,32'h1000,32'h1024));
    // Test 2: swapped write then duplicate.
    vt.push_back(mk(1,0,0,0,0,32'h1000,0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,32'h2040,32'h2000,0,32'h2020,
                    1,0,1,1,1,0,32'h2000,32'h2040));
    vt.push_back(mk(0,1,32'h2000,32'h2040,0,32'h2020,
                    1,0,1,1,1,0,32'h2000,32'h2040));
    vt.push_back(mk(0,0,0,0,0,32'h2041,0,0,1,1,1,0,32'h2000,32'h2040));
    // Test 3: drain handshake with back-pressure.
    vt.push_back(mk(1,0,0,0,0,32'h2020,0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,32'h100,32'h1FF,0,32'h150,
                    1,0,1,1,1,0,32'h100,32'h1FF));
    vt.push_back(mk(0,1,32'h300,32'h3FF,0,32'h350,
                    1,1,1,2,2,0,32'h100,32'h1FF));
    vt.push_back(mk(0,1,32'h500,32'h5FF,0,32'h550,
                    1,2,1,3,3,0,32'h100,32'h1FF));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(0,0,0,0,0,32'h100,1,0,1,3,3,0,32'h100,32'h1FF));
    vt.push_back(mk(0,0,0,0,1,32'h1FF,1,0,1,2,3,0,32'h300,32'h3FF));
    vt.push_back(mk(0,0,0,0,1,32'h3FF,1,1,1,1,3,0,32'h500,32'h5FF));
    vt.push_back(mk(0,0,0,0,1,32'h5FF,1,2,0,0,3,0,0,0));
    vt.push_back(mk(0,0,0,0,0,32'h600,0,0,0,0,3,0,0,0));

    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_valid", 32'(drain_valid_o), 0);
    chk("rst_pending", 32'(pending_o), 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_used", 32'(used_o), 0);
    chk("rst_lost", 32'(lost_o), 0);
    chk("rst_hit", 32'(lookup_hit_o), 0);
    chk("rst_idx", 32'(lookup_idx_o), 0);

    for (int k = 0; k < vt.size(); k++) begin
      drive(vt[k].clr, vt[k].wr, vt[k].f, vt[k].l,
            vt[k].rdy, vt[k].la);
      cyc();
      chk($sformatf("v%0d_hit", k), 32'(lookup_hit_o), 32'(vt[k].hit));
      chk($sformatf("v%0d_idx", k), 32'(lookup_idx_o), 32'(vt[k].idx));
      chk($sformatf("v%0d_dv", k), 32'(drain_valid_o), 32'(vt[k].dv));
      chk($sformatf("v%0d_pend", k), 32'(pending_o), 32'(vt[k].pend));
      chk($sformatf("v%0d_used", k), 32'(used_o), 32'(vt[k].used));
      chk($sformatf("v%0d_lost", k), 32'(lost_o), 32'(vt[k].lost));
      if (vt[k].dv) begin
        chk($sformatf("v%0d_df", k), drain_first_o, vt[k].df);
        chk($sformatf("v%0d_dl", k), drain_last_o, vt[k].dl);
      end
    end

    // Test 4: nine writes, no drain.
    clr_cycle();
    for (int i = 0; i < 9; i++) wr_cycle(rf(i), rf(i) + 32'hFF, 0);
    chk("ovf_used", 32'(used_o), 8);
    chk("ovf_pend", 32'(pending_o), 8);
    chk("ovf_lost", 32'(lost_o), 1);
    lookup_addr_i = rf(0) + 32'h10;
    #1 chk("ovf_r1_gone", 32'(lookup_hit_o), 0);
    lookup_addr_i = rf(8) + 32'hFF;
    #1 chk("ovf_r9_hit", 32'(lookup_hit_o), 1);
    chk("ovf_r9_idx", 32'(lookup_idx_o), 0);
    lookup_addr_i = rf(1);
    #1 chk("ovf_r2_idx", 32'(lookup_idx_o), 1);
    chk("ovf_drain_first", drain_first_o, rf(1));
    chk("ovf_drain_last", drain_last_o, rf(1) + 32'hFF);
    clr_cycle();
    chk("clr_lost", 32'(lost_o), 0);
    chk("clr_used", 32'(used_o), 0);

    // Test 5: full table, ninth write with concurrent drain.
    for (int i = 0; i < 8; i++) wr_cycle(rf(i), rf(i) + 32'hFF, 0);
    chk("full_pend", 32'(pending_o), 8);
    chk("full_present_r1", drain_first_o, rf(0));
    wr_cycle(rf(8), rf(8) + 32'hFF, 1);
    chk("cdr_lost", 32'(lost_o), 0);
    chk("cdr_pend", 32'(pending_o), 8);
    chk("cdr_used", 32'(used_o), 8);
    chk("cdr_next", drain_first_o, rf(1));

    // Test 6a: clear beats a simultaneous write.
    clr_cycle();
    for (int i = 0; i < 5; i++) wr_cycle(rf(i), rf(i) + 32'hFF, 0);
    chk("five_used", 32'(used_o), 5);
    drive(1, 1, 32'h9_0000, 32'h9_00FF, 1, 32'h9_0010);
    cyc();
    chk("cw_hit", 32'(lookup_hit_o), 0);
    chk("cw_dv", 32'(drain_valid_o), 0);
    chk("cw_pend", 32'(pending_o), 0);
    chk("cw_used", 32'(used_o), 0);
    chk("cw_lost", 32'(lost_o), 0);
    lookup_addr_i = rf(2);
    #1 chk("cw_old_gone", 32'(lookup_hit_o), 0);
    wr_cycle(32'h7000, 32'h70FF, 0);
    lookup_addr_i = 32'h7000;
    #1 chk("post_clr_idx0", 32'(lookup_idx_o), 0);
    chk("post_clr_hit", 32'(lookup_hit_o), 1);

    // Test 6b: async reset mid-drain.
    clr_cycle();
    for (int i = 0; i < 3; i++) wr_cycle(rf(i), rf(i) + 32'hFF, 0);
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    drain_ready_i = 1'b1;
    chk("mid_pend", 32'(pending_o), 2);
    #2 rst_ni = 1'b0;
    #1 chk("arst_dv", 32'(drain_valid_o), 0);
    chk("arst_used", 32'(used_o), 0);
    chk("arst_pend", 32'(pending_o), 0);
    drain_ready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1 chk("arst_after", 32'(drain_valid_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
